uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for 8N1 frames: one start bit (low), 8 data bits LSB-first, one stop bit (high), idle high. It samples the line at 16x the bit rate and votes on each bit at mid-bit. It delivers each byte through a valid/ack handshake and flags framing errors and overruns. It is the receive counterpart of the UART transmitter: it sits behind a pin input and feeds a byte consumer on the `ref_clk` domain.

## Interface
- No parameters. Rate is set entirely by `sample_clk`.
- `ref_clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sample_clk` input 1: oversample enable, one `ref_clk` cycle wide, 16 pulses per bit period; minimum spacing 2 `ref_clk` cycles.
- `in` input 1: asynchronous serial line.
- `ack` input 1: consumer has taken `data`; meaningful only while `valid`=1.
- `data` output [0:7]: received byte. First data bit on the wire lands in `data[7]`, last in `data[0]`, so byte 0xA5 reads back as vector value 8'hA5.
- `valid` output 1: `data` holds an unconsumed byte.
- `overrun` output 1: sticky; a byte was dropped because `valid` was still set.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `busy` output 1: high in every state except IDLE.

## Operation
- `in` passes through a 2-flop synchronizer (reset value 1) to give `rxs`. All decisions use `rxs`, evaluated only on cycles with `sample_clk`=1 (a "tick").
- Internal counters:
  - 4-bit tick counter `tcnt`, wraps 15→0.
  - 3-bit bit counter.
  - 3-sample history holding `rxs` at the last 3 ticks.
  - Bit decision = majority of the 3 samples taken at `tcnt`=6,7,8; it is made on the tick where `tcnt`=8.
- States:
  - IDLE: on a tick with `rxs`=0, go to START with `tcnt`←1. That tick counts as `tcnt`=0.
  - START: at the decision tick, a vote of 1 is a false start: go to IDLE with no outputs changed. A vote of 0 moves to DATA with bit counter=0 and `tcnt`←9.
  - DATA: at each decision tick, shift the vote into the byte shift register. After the 8th bit, go to STOP.
  - STOP:
    - Vote 1: deliver the byte and go to IDLE.
    - Vote 0: pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for a tick with `rxs`=1, then go to IDLE. A held-low line never produces repeated starts.
- Delivery:
  - `valid`=0, or `valid`=1 with `ack`=1 in the same cycle: load `data`, `valid`←1.
  - `valid`=1 with `ack`=0: keep the old `data`, drop the new byte, `overrun`←1.
- `ack` with `valid`=1 and no delivery that cycle: `valid`←0 and `overrun`←0 next cycle. `ack` while `valid`=0 is ignored.
- Returning to IDLE at mid-stop-bit gives half a bit of resync margin for back-to-back frames.
- Reset mid-frame: abandon the frame and go to IDLE. The next clean frame is received correctly.

## Timing
- Reset values: `data`=0, `valid`=0, `overrun`=0, `frame_err`=0, `busy`=0, state IDLE, synchronizer=1.
- Pin to `rxs`: 2 `ref_clk` cycles.
- Start detection happens on the first tick at which `rxs`=0.
- Detect tick to stop-bit decision tick: 8 + 16×9 = 152 ticks.
- `valid` and `data` update on the `ref_clk` edge after the stop decision tick. `frame_err` is high for exactly that one cycle.
- `busy` rises the cycle after the detect tick and falls the cycle after the stop decision (or after the BREAK exit).
- Rate tolerance: a bit-rate error up to ±3% must still decode correctly.
- Non-tick cycles change no state except the synchronizer and the handshake logic.

## Test plan
- Single byte: `sample_clk` every 4 cycles (64 cycles per bit); send 0xA5 → `data`=8'hA5, `valid`=1 exactly 152 ticks + 1 cycle after the detect tick; `ack` → `valid`=0 next cycle.
- Back-to-back frames 0x00, 0xFF, 0x3C with `ack` 1 cycle after each `valid` → three deliveries, in order, no `overrun`/`frame_err`; `busy` low only between frames.
- Glitch: 2-tick low pulse on idle line → false start, no `valid`, `busy` back to 0 by tick 9. Single-tick glitch at a mid-bit sample of 0x55 → 0x55 still received (majority).
- Framing: 0x81 with stop bit low, then line held low 3 bit times → one `frame_err` pulse, `valid` stays 0, no further starts until line high; next 0x42 received.
- Overrun: send 0x11 then 0x22 without `ack` → `data`=0x11, `overrun`=1; `ack` → `valid`=0, `overrun`=0. Repeat with `ack` coinciding with the 0x22 delivery → `data`=0x22, `valid`=1, `overrun`=0.
- Reset mid-frame: assert `reset` 1 cycle during bit 4 of 0xC3 → all outputs 0 next cycle; following 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and mid-bit 3-sample
// majority vote. Delivers bytes via a valid/ack handshake and reports
// framing errors (one-cycle pulse) and overruns (sticky until ack).
module uart_rx (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       sample_clk,
    input  logic       in,
    input  logic       ack,
    output logic [0:7] data,
    output logic       valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t     state_q;
    logic [1:0] sync_q;
    logic [3:0] tcnt_q;
    logic [2:0] bcnt_q;
    logic [1:0] hist_q;     // rxs at the previous two ticks; the current rxs is the third sample
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [0:7] data_q;
    logic       valid_q;
    logic       overrun_q;
    logic       frame_err_q;
    logic       busy_q;

    logic       rxs;
    logic       vote;
    logic       decide;
    logic       deliver;

    assign rxs     = sync_q[1];
    assign vote    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
    assign decide  = sample_clk && (tcnt_q == 4'd8);
    assign deliver = decide && (state_q == S_STOP) && vote;
    // LSB arrives first, so each new bit enters at the top and ends up at bit 0 after 8 shifts
    assign shreg_d = {vote, shreg_q[7:1]};

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

    // Two-flop synchronizer on the asynchronous line, idling high
    always_ff @(posedge ref_clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], in};
    end

    // Receive FSM, sample history and consumer handshake
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tcnt_q      <= 4'd0;
            bcnt_q      <= 3'd0;
            hist_q      <= 2'b11;
            shreg_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // Handshake runs every cycle; a same-cycle ack makes room for the new byte
            if (deliver) begin
                if (!valid_q || ack) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ack) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (sample_clk) begin
                hist_q <= {hist_q[0], rxs};
                if (state_q != S_IDLE) tcnt_q <= tcnt_q + 4'd1;

                case (state_q)
                    S_IDLE: begin
                        // The detect tick is tcnt 0, so the next tick is tcnt 1
                        if (!rxs) begin
                            state_q <= S_START;
                            tcnt_q  <= 4'd1;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tcnt_q == 4'd8) begin
                            if (vote) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_DATA;
                                bcnt_q  <= 3'd0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (tcnt_q == 4'd8) begin
                            shreg_q <= shreg_d;
                            bcnt_q  <= bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // Leaving at mid-stop-bit leaves half a bit of resync margin
                        if (tcnt_q == 4'd8) begin
                            if (vote) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        // A held-low line must go high before another start is accepted
                        if (rxs) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a byte-level model of
// the receiver (expected byte, valid, overrun, frame error count).
module tb_uart_rx;

    logic       ref_clk;
    logic       reset;
    logic       sample_clk;
    logic       rx_line;
    logic       ack;
    logic [0:7] data;
    logic       valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int fe_cnt = 0;
    int fe_long = 0;

    // model of the consumer-visible state
    logic       mvalid;
    logic       movr;
    logic [7:0] mdata;

    uart_rx dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .sample_clk (sample_clk),
        .in         (rx_line),
        .ack        (ack),
        .data       (data),
        .valid      (valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    // cycle k (after edge k) is a tick when k % 4 == 0
    initial begin
        sample_clk = 1'b0;
        forever begin
            @(posedge ref_clk);
            cyc++;
            #1 sample_clk = (cyc % 4 == 0);
        end
    end

    // count frame_err pulses and any pulse longer than one cycle
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge ref_clk);
            if (frame_err === 1'b1) fe_cnt++;
            if (frame_err === 1'b1 && prev) fe_long++;
            prev = (frame_err === 1'b1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) cyc_wait(1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cyc_wait(1);
        ack = 1'b0;
    endtask

    task automatic m_deliver(input logic [7:0] b, input bit ack_now);
        if (!mvalid || ack_now) begin
            mdata  = b;
            mvalid = 1'b1;
        end else begin
            movr = 1'b1;
        end
    endtask

    task automatic m_ack();
        if (mvalid) begin
            mvalid = 1'b0;
            movr   = 1'b0;
        end
    endtask

    // Drive one frame, bit period bc cycles. gbit>=0 inverts the line for 4
    // cycles near mid-bit of that data bit. rst_at>=0 pulses reset at that
    // cycle offset and abandons the frame with the line returned high.
    task automatic send(input logic [7:0] b, input bit stopb, input int bc,
                        input int gbit, input int rst_at);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int c = 0; c < 10 * bc; c++) begin
            int   bi;
            int   off;
            logic v;
            bi  = c / bc;
            off = c % bc;
            v   = fr[bi];
            if (bi - 1 == gbit && off >= 28 && off < 32) v = ~v;
            if (c == rst_at) begin
                reset   = 1'b1;
                rx_line = 1'b1;
                cyc_wait(1);
                reset = 1'b0;
                return;
            end
            rx_line = v;
            cyc_wait(1);
        end
    endtask

    // first tick cycle at which the synchronized line shows the start bit
    function automatic int detect_tick(input int s);
        return ((s + 2 + 3) / 4) * 4;
    endfunction

    task automatic wait_valid(input string tag, input int lim);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < lim) begin
            cyc_wait(1);
            n++;
        end
        chk(tag, valid, 1'b1);
    endtask

    initial begin
        int s;
        int t;
        int fe0;
        logic [7:0] b2b [3];
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h3C;

        reset   = 1'b1;
        rx_line = 1'b1;
        ack     = 1'b0;
        cyc_wait(5);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        cyc_wait(20);

        // single byte with exact latency
        s = cyc;
        t = detect_tick(s);
        fork
            send(8'hA5, 1'b1, 64, -1, -1);
            begin
                wait_until(t);
                chk("a5_busy_pre", busy, 1'b0);
                cyc_wait(1);
                chk("a5_busy_rise", busy, 1'b1);
                wait_until(t + 608);
                chk("a5_valid_early", valid, 1'b0);
                cyc_wait(1);
                chk("a5_valid", valid, 1'b1);
                chk("a5_data", data, 8'hA5);
                chk("a5_busy_fall", busy, 1'b0);
            end
        join
        cyc_wait(8);
        pulse_ack();
        chk("a5_ack_valid", valid, 1'b0);

        // back-to-back frames with a consumer acking one cycle after valid
        fe0 = fe_cnt;
        fork
            begin
                for (int i = 0; i < 3; i++) send(b2b[i], 1'b1, 64, -1, -1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    wait_valid("b2b_valid", 2000);
                    chk("b2b_data", data, b2b[i]);
                    chk("b2b_ovr", overrun, 1'b0);
                    cyc_wait(1);
                    pulse_ack();
                end
            end
        join
        cyc_wait(40);
        chk("b2b_ferr", fe_cnt - fe0, 0);
        chk("b2b_busy_end", busy, 1'b0);
        chk("b2b_valid_end", valid, 1'b0);

        // two-tick low glitch on idle line is a false start
        s = cyc;
        t = detect_tick(s);
        rx_line = 1'b0;
        cyc_wait(8);
        rx_line = 1'b1;
        wait_until(t + 1);
        chk("glitch_busy", busy, 1'b1);
        wait_until(t + 36);
        chk("glitch_busy_off", busy, 1'b0);
        cyc_wait(100);
        chk("glitch_valid", valid, 1'b0);

        // single-tick glitch at a mid-bit sample is outvoted
        send(8'h55, 1'b1, 64, $urandom_range(0, 7), -1);
        cyc_wait(4);
        chk("vote_valid", valid, 1'b1);
        chk("vote_data", data, 8'h55);
        pulse_ack();

        // framing error followed by a held-low line
        fe0 = fe_cnt;
        send(8'h81, 1'b0, 64, -1, -1);
        cyc_wait(3 * 64);
        chk("frm_pulses", fe_cnt - fe0, 1);
        chk("frm_valid", valid, 1'b0);
        chk("frm_busy_break", busy, 1'b1);
        rx_line = 1'b1;
        cyc_wait(10);
        chk("frm_busy_idle", busy, 1'b0);
        chk("frm_pulses_after", fe_cnt - fe0, 1);
        cyc_wait(64);
        send(8'h42, 1'b1, 64, -1, -1);
        cyc_wait(4);
        chk("frm_next_data", data, 8'h42);
        chk("frm_next_valid", valid, 1'b1);
        pulse_ack();

        // overrun without ack
        send(8'h11, 1'b1, 64, -1, -1);
        send(8'h22, 1'b1, 64, -1, -1);
        cyc_wait(4);
        chk("ovr_data", data, 8'h11);
        chk("ovr_flag", overrun, 1'b1);
        pulse_ack();
        chk("ovr_ack_valid", valid, 1'b0);
        chk("ovr_ack_flag", overrun, 1'b0);

        // ack coinciding with the delivery of the second byte
        send(8'h11, 1'b1, 64, -1, -1);
        s = cyc;
        t = detect_tick(s);
        fork
            send(8'h22, 1'b1, 64, -1, -1);
            begin
                wait_until(t + 608);
                pulse_ack();
                chk("coin_data", data, 8'h22);
                chk("coin_valid", valid, 1'b1);
                chk("coin_ovr", overrun, 1'b0);
            end
        join

        // reset during bit 4 of 0xC3 (valid still holding 0x22)
        send(8'hC3, 1'b1, 64, -1, 64 * 5 + 32);
        chk("mrst_data", data, 8'h00);
        chk("mrst_valid", valid, 1'b0);
        chk("mrst_ovr", overrun, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        cyc_wait(64);
        send(8'h5A, 1'b1, 64, -1, -1);
        cyc_wait(4);
        chk("mrst_next_data", data, 8'h5A);
        chk("mrst_next_valid", valid, 1'b1);
        pulse_ack();

        // randomized frames, rate error, bad stops and ack timing vs model
        mvalid = 1'b0;
        movr   = 1'b0;
        mdata  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            int         bc;
            bit         good;
            b    = 8'($urandom_range(0, 255));
            bc   = $urandom_range(62, 66);
            good = ($urandom_range(0, 5) != 0);
            fe0  = fe_cnt;
            send(b, good, bc, -1, -1);
            rx_line = 1'b1;
            cyc_wait(bc);
            if (good) m_deliver(b, 1'b0);
            chk("rnd_ferr", fe_cnt - fe0, good ? 0 : 1);
            chk("rnd_valid", valid, mvalid);
            chk("rnd_ovr", overrun, movr);
            if (mvalid) chk("rnd_data", data, mdata);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                m_ack();
                chk("rnd_ack_valid", valid, mvalid);
                chk("rnd_ack_ovr", overrun, movr);
            end
        end

        chk("ferr_width", fe_long, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
